// File: rtl/lamp_driver.sv
// Three-channel lamp PWM driver: fades the duty toward a luminosity-derived target and
// switches colour only at PWM period boundaries so no channel ever emits a runt pulse.
module lamp_driver #(
  parameter int unsigned         PWM_BITS = 8,
  parameter int unsigned         FADE_DIV = 4,
  parameter logic [PWM_BITS-1:0] LVL_HIGH = PWM_BITS'(255),
  parameter logic [PWM_BITS-1:0] LVL_MID  = PWM_BITS'(170),
  parameter logic [PWM_BITS-1:0] LVL_LOW  = PWM_BITS'(85)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          luminosity,
  input  logic [1:0]          color,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int unsigned PreW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  // Counter stops one short of all-ones so a full-scale duty keeps the channel solidly on.
  localparam logic [PWM_BITS-1:0] CntMax = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PreW-1:0]     PreMax = PreW'(FADE_DIV - 1);

  typedef enum logic [1:0] {StIdle, StFadeUp, StFadeDown} state_e;

  state_e              state_q, state_d;
  logic [1:0]          lum_q, col_q, col_act_q;
  logic [PWM_BITS-1:0] pwm_cnt_q, duty_q, duty_d, target;
  logic [PreW-1:0]     pre_q;
  logic                pwm_r_q, pwm_g_q, pwm_b_q;
  logic                tick, wrap, chan_on;
  logic [2:0]          mask;

  always_comb begin
    target = '0;
    case (lum_q)
      2'b11:   target = LVL_HIGH;
      2'b10:   target = LVL_MID;
      2'b01:   target = LVL_LOW;
      default: target = '0;
    endcase
  end

  assign tick    = (pre_q == PreMax);
  assign wrap    = (pwm_cnt_q == CntMax);
  assign chan_on = (pwm_cnt_q < duty_q);

  always_comb begin
    mask = 3'b111;
    unique case (col_act_q)
      2'b00: mask = 3'b111;
      2'b01: mask = 3'b100;
      2'b10: mask = 3'b010;
      2'b11: mask = 3'b001;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lum_q     <= 2'b00;
      col_q     <= 2'b00;
      col_act_q <= 2'b00;
      pwm_cnt_q <= '0;
      pre_q     <= '0;
      duty_q    <= '0;
      pwm_r_q   <= 1'b0;
      pwm_g_q   <= 1'b0;
      pwm_b_q   <= 1'b0;
    end else begin
      lum_q     <= luminosity;
      col_q     <= color;
      pwm_cnt_q <= wrap ? '0 : pwm_cnt_q + PWM_BITS'(1);
      pre_q     <= tick ? '0 : pre_q + PreW'(1);
      duty_q    <= duty_d;
      if (wrap) col_act_q <= col_q;
      pwm_r_q   <= chan_on & mask[2];
      pwm_g_q   <= chan_on & mask[1];
      pwm_b_q   <= chan_on & mask[0];
    end
  end

  // Fade FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Fade FSM: direction chosen afresh every clock, so a new target simply reverses the fade.
  always_comb begin
    state_d = StIdle;
    if (duty_q < target)      state_d = StFadeUp;
    else if (duty_q > target) state_d = StFadeDown;
  end

  // Fade FSM: outputs. The target compare guards against overshoot when the target moves.
  always_comb begin
    duty_d = duty_q;
    if (tick) begin
      case (state_q)
        StFadeUp:   if (duty_q < target) duty_d = duty_q + PWM_BITS'(1);
        StFadeDown: if (duty_q > target) duty_d = duty_q - PWM_BITS'(1);
        default:    duty_d = duty_q;
      endcase
    end
  end

  assign busy  = (state_q != StIdle);
  assign duty  = duty_q;
  assign pwm_r = pwm_r_q;
  assign pwm_g = pwm_g_q;
  assign pwm_b = pwm_b_q;

endmodule

// File: tb/tb_lamp_driver.sv
// Scoreboard bench for lamp_driver: stimulus queues hand-computed expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_lamp_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] luminosity, color;
  logic       pwm_r, pwm_g, pwm_b, busy;
  logic [7:0] duty;

  lamp_driver dut (
    .clk        (clk),
    .reset      (reset),
    .luminosity (luminosity),
    .color      (color),
    .pwm_r      (pwm_r),
    .pwm_g      (pwm_g),
    .pwm_b      (pwm_b),
    .duty       (duty),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  localparam int SelDuty = 0, SelBusy = 1, SelR = 2, SelG = 3, SelB = 4, SelMeas = 5;

  typedef struct {
    string name;
    int    sel;
    int    exp;
    int    meas;
  } item_t;

  item_t sb_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  function automatic int actual_of(input item_t it);
    case (it.sel)
      SelDuty: return int'(duty);
      SelBusy: return int'(busy);
      SelR:    return int'(pwm_r);
      SelG:    return int'(pwm_g);
      SelB:    return int'(pwm_b);
      default: return it.meas;
    endcase
  endfunction

  // Monitor: compares every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      item_t it;
      int    act;
      it  = sb_q.pop_front();
      act = actual_of(it);
      n_total++;
      if (act == it.exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", it.name, act, it.exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_v(input string name, input int sel, input int exp);
    sb_q.push_back('{name, sel, exp, 0});
  endtask

  task automatic expect_meas(input string name, input int meas, input int exp);
    sb_q.push_back('{name, SelMeas, exp, meas});
  endtask

  task automatic expect_outs_low(input string tag);
    expect_v({tag, "_duty"}, SelDuty, 0);
    expect_v({tag, "_busy"}, SelBusy, 0);
    expect_v({tag, "_r"}, SelR, 0);
    expect_v({tag, "_g"}, SelG, 0);
    expect_v({tag, "_b"}, SelB, 0);
  endtask

  task automatic wait_duty(input int target, input int budget, input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (int'(duty) == target) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    expect_meas(name, ok, 1);
  endtask

  task automatic count_pwm(input int n, output int cr, output int cg, output int cb);
    cr = 0;
    cg = 0;
    cb = 0;
    repeat (n) begin
      tick(1);
      cr += int'(pwm_r);
      cg += int'(pwm_g);
      cb += int'(pwm_b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cr, cg, cb, maxd, incs, prev, found;
    logic prev_r;

    // Reset state, then fade 0 -> 85 with white colour.
    reset = 1'b1; luminosity = 2'b00; color = 2'b00;
    tick(3);
    expect_outs_low("reset");
    reset = 1'b0; luminosity = 2'b01;
    tick(2);
    expect_v("t1_busy_rise", SelBusy, 1);
    expect_v("t1_duty_e2", SelDuty, 0);
    tick(2);
    expect_v("t1_duty_first_step", SelDuty, 1);
    tick(335);
    expect_v("t1_duty_e339", SelDuty, 84);
    expect_v("t1_busy_e339", SelBusy, 1);
    tick(1);
    expect_v("t1_duty_reach", SelDuty, 85);
    expect_v("t1_busy_at_reach", SelBusy, 1);
    tick(1);
    expect_v("t1_busy_drop", SelBusy, 0);
    expect_v("t1_duty_hold", SelDuty, 85);
    count_pwm(255, cr, cg, cb);
    expect_meas("t1_r_high_count", cr, 85);
    expect_meas("t1_g_high_count", cg, 85);
    expect_meas("t1_b_high_count", cb, 85);

    // Full-scale duty keeps every channel solidly on.
    luminosity = 2'b11;
    wait_duty(255, 255 * 4 + 10, "t2_reach_255");
    tick(3);
    expect_v("t2_busy_idle_255", SelBusy, 0);
    count_pwm(510, cr, cg, cb);
    expect_meas("t2_r_always_on", cr, 510);
    expect_meas("t2_g_always_on", cg, 510);
    expect_meas("t2_b_always_on", cb, 510);

    // Fade down to zero, then everything stays off.
    luminosity = 2'b00;
    wait_duty(0, 255 * 4 + 10, "t3_reach_0");
    tick(3);
    expect_v("t3_busy_idle_0", SelBusy, 0);
    count_pwm(510, cr, cg, cb);
    expect_meas("t3_r_always_off", cr, 0);
    expect_meas("t3_g_always_off", cg, 0);
    expect_meas("t3_b_always_off", cb, 0);

    // Reversal at duty 100 toward 85: no overshoot, monotonic descent.
    luminosity = 2'b11;
    wait_duty(100, 100 * 4 + 10, "t4_reach_100");
    luminosity = 2'b01;
    maxd = int'(duty);
    incs = 0;
    prev = int'(duty);
    repeat (60) begin
      tick(1);
      if (int'(duty) > maxd) maxd = int'(duty);
      if (int'(duty) > prev) incs++;
      prev = int'(duty);
      if (prev == 99 && maxd == 100 && incs == 0 && int'(duty) == 99) begin end
    end
    expect_v("t4_duty_at_85", SelDuty, 85);
    expect_v("t4_busy_at_85", SelBusy, 1);
    expect_meas("t4_max_duty", maxd, 100);
    expect_meas("t4_increases", incs, 0);
    tick(1);
    expect_v("t4_busy_drop", SelBusy, 0);

    // Colour change at pwm_cnt 40 with duty 170 lands on the next period boundary.
    luminosity = 2'b10;
    wait_duty(170, 85 * 4 + 10, "t5_reach_170");
    tick(3);
    found  = 0;
    prev_r = pwm_r;
    for (int i = 0; i < 600; i++) begin
      tick(1);
      if (!prev_r && pwm_r) begin
        found = 1;
        break;
      end
      prev_r = pwm_r;
    end
    expect_meas("t5_period_start_found", found, 1);
    tick(39);
    color = 2'b01;
    count_pwm(510, cr, cg, cb);
    expect_meas("t5_r_high_count", cr, 340);
    expect_meas("t5_g_high_count", cg, 130);
    expect_meas("t5_b_high_count", cb, 130);

    // Reset during a fade-up at duty 120, then restart toward 170.
    color = 2'b00;
    luminosity = 2'b00;
    wait_duty(0, 170 * 4 + 10, "t6_reach_0");
    luminosity = 2'b11;
    wait_duty(120, 120 * 4 + 10, "t6_reach_120");
    reset = 1'b1;
    luminosity = 2'b10;
    tick(1);
    expect_outs_low("t6_reset");
    reset = 1'b0;
    tick(2);
    expect_v("t6_busy_rise", SelBusy, 1);
    expect_v("t6_duty_e2", SelDuty, 0);
    tick(2);
    expect_v("t6_duty_first_step", SelDuty, 1);
    tick(675);
    expect_v("t6_duty_e679", SelDuty, 169);
    tick(1);
    expect_v("t6_duty_reach", SelDuty, 170);
    expect_v("t6_busy_at_reach", SelBusy, 1);
    tick(1);
    expect_v("t6_busy_drop", SelBusy, 0);

    tick(2);
    if (n_total < 12) $display("FAIL check_count: got %0d, expected at least 12", n_total);
    if (n_pass != n_total) $display("FAIL summary: got %0d, expected %0d", n_pass, n_total);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
